// File: rtl/imem_loader.sv
// Instruction memory for the fetch stage. Returns the word at PC in run mode.
// In load mode it packs a little-endian UART byte stream into words, written from address 0.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           PC,
    output logic [31:0]           instruction,
    input  logic                  load_en,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow,
    output logic                  fetch_fault
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_t;

    state_t                state;
    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH:0]   wr_addr;
    logic [31:0]           word_buf;
    logic [31:0]           mem [2**ADDR_WIDTH];

    logic                  full;
    logic                  accept;
    logic                  fetch_bad;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    always_comb begin
        full       = (word_count == DEPTH);
        accept     = (state == StLoad) && rx_valid && !full;
        fetch_bad  = (PC[1:0] != 2'b00) || ((PC >> (ADDR_WIDTH + 2)) != 32'd0);
        fetch_addr = PC[ADDR_WIDTH+1:2];
        mem_we     = 1'b0;
        mem_waddr  = wr_addr[ADDR_WIDTH-1:0];
        mem_wdata  = word_buf;
        if (accept && byte_idx == 2'd3) begin
            mem_we    = 1'b1;
            mem_wdata = {rx_byte, word_buf[23:0]};
        end else if (state == StFlush && byte_idx != 2'd0) begin
            // word_buf is zeroed after each full word, so unfilled lanes are already zero
            mem_we = 1'b1;
        end
    end

    // Memory has no reset: contents survive rst and later loads.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            instruction <= NOP_WORD;
            cpu_hold    <= 1'b0;
            load_done   <= 1'b0;
            word_count  <= '0;
            overflow    <= 1'b0;
            fetch_fault <= 1'b0;
            byte_idx    <= 2'd0;
            wr_addr     <= '0;
            word_buf    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    instruction <= fetch_bad ? NOP_WORD : mem[fetch_addr];
                    if (fetch_bad) begin
                        fetch_fault <= 1'b1;
                    end
                    if (load_en) begin
                        state      <= StLoad;
                        cpu_hold   <= 1'b1;
                        byte_idx   <= 2'd0;
                        wr_addr    <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        word_buf   <= '0;
                    end
                end
                StLoad: begin
                    instruction <= NOP_WORD;
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr_addr    <= wr_addr + (ADDR_WIDTH + 1)'(1);
                            word_count <= word_count + (ADDR_WIDTH + 1)'(1);
                            word_buf   <= '0;
                        end else begin
                            word_buf[byte_idx*8 +: 8] <= rx_byte;
                        end
                    end
                    if (rx_valid && full) begin
                        overflow <= 1'b1;
                    end
                    if (!load_en) begin
                        state <= StFlush;
                    end
                end
                StFlush: begin
                    instruction <= NOP_WORD;
                    if (byte_idx != 2'd0) begin
                        word_count <= word_count + (ADDR_WIDTH + 1)'(1);
                    end
                    load_done <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    instruction <= NOP_WORD;
                    load_done   <= 1'b0;
                    cpu_hold    <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader, built with a 4-word memory so the full/overflow
// boundary is reachable with a short byte stream.
module tb_imem_loader;

    localparam int unsigned AW  = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   PC = 32'd0;
    logic [31:0]   instruction;
    logic          load_en = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'd0;
    logic          cpu_hold;
    logic          load_done;
    logic [AW:0]   word_count;
    logic          overflow;
    logic          fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    imem_loader #(.ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .PC(PC), .instruction(instruction),
        .load_en(load_en), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .cpu_hold(cpu_hold), .load_done(load_done), .word_count(word_count),
        .overflow(overflow), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        PC = addr;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instruction, NOP); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", cpu_hold); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", load_done); end
        n_checks++; if (word_count !== 3'd0) begin n_fail++; $display("FAIL reset_wc: got %0d want 0", word_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_byte_load();
        logic [7:0] bytes [8];
        bytes = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'ha0, 8'h00};
        load_en = 1'b1;
        step();
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL load_hold_entry: got %b want 1", cpu_hold); end
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL load_instr_nop: got %h want %h", instruction, NOP); end
        n_checks++; if (word_count !== 3'd2) begin n_fail++; $display("FAIL load_wc: got %0d want 2", word_count); end
        load_en = 1'b0;
        step();
        n_checks++; if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL load_flush_edge: got done=%b hold=%b want done=0 hold=1", load_done, cpu_hold); end
        step();
        n_checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL load_done_edge: got done=%b hold=%b want done=1 hold=1", load_done, cpu_hold); end
        step();
        n_checks++; if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL load_idle_edge: got done=%b hold=%b want done=0 hold=0", load_done, cpu_hold); end
        n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL load_idle_instr: got %h want %h", instruction, NOP); end
        step();
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL load_done_single: got %b want 0", load_done); end
    endtask

    task automatic test_run();
        fetch(32'd0);
        n_checks++; if (instruction !== 32'h00500093) begin n_fail++; $display("FAIL run_pc0: got %h want 00500093", instruction); end
        fetch(32'd4);
        n_checks++; if (instruction !== 32'h00a00113) begin n_fail++; $display("FAIL run_pc4: got %h want 00a00113", instruction); end
        n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL run_fault: got %b want 0", fetch_fault); end
    endtask

    task automatic test_partial();
        logic [7:0] bytes [5];
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        PC = 32'd0;
        load_en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        load_en = 1'b0;
        repeat (3) step();
        n_checks++; if (word_count !== 3'd2) begin n_fail++; $display("FAIL partial_wc: got %0d want 2", word_count); end
        fetch(32'd0);
        n_checks++; if (instruction !== 32'h04030201) begin n_fail++; $display("FAIL partial_w0: got %h want 04030201", instruction); end
        fetch(32'd4);
        n_checks++; if (instruction !== 32'h000000AA) begin n_fail++; $display("FAIL partial_w1: got %h want 000000aa", instruction); end
    endtask

    task automatic test_simultaneous();
        PC = 32'd0;
        load_en = 1'b1;
        step();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rx_valid = 1'b1;
        rx_byte  = 8'h44;
        load_en  = 1'b0;
        step();
        rx_valid = 1'b0;
        repeat (2) step();
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL simul_hold: got %b want 0", cpu_hold); end
        n_checks++; if (word_count !== 3'd1) begin n_fail++; $display("FAIL simul_wc: got %0d want 1", word_count); end
        fetch(32'd0);
        n_checks++; if (instruction !== 32'h44332211) begin n_fail++; $display("FAIL simul_w0: got %h want 44332211", instruction); end
        fetch(32'd4);
        n_checks++; if (instruction !== 32'h000000AA) begin n_fail++; $display("FAIL simul_w1_kept: got %h want 000000aa", instruction); end
    endtask

    task automatic test_overflow();
        PC = 32'd0;
        load_en = 1'b1;
        step();
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
        n_checks++; if (word_count !== 3'd4) begin n_fail++; $display("FAIL ovf_wc: got %0d want 4", word_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        load_en = 1'b0;
        repeat (3) step();
        n_checks++; if (word_count !== 3'd4 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_done: got wc=%0d ovf=%b want wc=4 ovf=1", word_count, overflow); end
        fetch(32'd12);
        n_checks++; if (instruction !== 32'h100f0e0d) begin n_fail++; $display("FAIL ovf_w3: got %h want 100f0e0d", instruction); end
        fetch(32'd0);
        n_checks++; if (instruction !== 32'h04030201) begin n_fail++; $display("FAIL ovf_w0: got %h want 04030201", instruction); end
    endtask

    task automatic test_mid_reset();
        PC = 32'd0;
        load_en = 1'b1;
        step();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf_cleared: got %b want 0", overflow); end
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA1 + i));
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (cpu_hold !== 1'b0 || word_count !== 3'd0) begin n_fail++; $display("FAIL midrst_abort: got hold=%b wc=%0d want hold=0 wc=0", cpu_hold, word_count); end
        load_en = 1'b0;
        #4;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b want 0", load_done); end
        end
        n_checks++; if (word_count !== 3'd0) begin n_fail++; $display("FAIL midrst_wc: got %0d want 0", word_count); end
        fetch(32'd0);
        n_checks++; if (instruction !== 32'ha4a3a2a1) begin n_fail++; $display("FAIL midrst_w0: got %h want a4a3a2a1", instruction); end
        fetch(32'd4);
        n_checks++; if (instruction !== 32'h08070605) begin n_fail++; $display("FAIL midrst_w1_kept: got %h want 08070605", instruction); end
    endtask

    task automatic test_faults();
        fetch(32'h100);
        n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL fault_range_instr: got %h want %h", instruction, NOP); end
        n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL fault_range_flag: got %b want 1", fetch_fault); end
        fetch(32'd0);
        n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %b want 1", fetch_fault); end
        rst = 1'b1;
        #3;
        rst = 1'b0;
        n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL fault_rst_clear: got %b want 0", fetch_fault); end
        fetch(32'd2);
        n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL fault_align_instr: got %h want %h", instruction, NOP); end
        n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL fault_align_flag: got %b want 1", fetch_fault); end
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_run();
        test_partial();
        test_simultaneous();
        test_overflow();
        test_mid_reset();
        test_faults();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
